// File: rtl/tx_sym_scheduler.sv
// tx_sym_scheduler: generates sample/symbol clock enables for the SRRC
// transmit filter, pops PAM symbols once per symbol from a valid/ready
// source (zero-stuffing on underflow), and flushes the filter delay line
// with zero symbols after stop.
module tx_sym_scheduler #(
  parameter int CLK_PER_SAM = 4,
  parameter int FLUSH_SYMS  = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        s_valid,
  input  logic [17:0] s_data,
  output logic        s_ready,
  output logic        sam_clk_en,
  output logic        sym_clk_en,
  output logic [17:0] sym_out,
  output logic        busy,
  output logic [15:0] underflow_cnt
);

  localparam int DIV_W = (CLK_PER_SAM > 2) ? $clog2(CLK_PER_SAM) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX    = DIV_W'(CLK_PER_SAM - 1);
  localparam logic [7:0]       FLUSH_LOAD = 8'(FLUSH_SYMS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       sam_idx_q, sam_idx_d;
  logic             stop_pend_q, stop_pend_d;
  logic [7:0]       flush_cnt_q, flush_cnt_d;
  logic [17:0]      sym_out_q, sym_out_d;
  logic [15:0]      underflow_cnt_q, underflow_cnt_d;

  // Free-running strobe decode; depends only on registers so the filter keeps draining in any state.
  always_comb begin
    sam_clk_en = (div_cnt_q == DIV_MAX);
    sym_clk_en = sam_clk_en & (sam_idx_q == 2'd3);
    div_cnt_d  = sam_clk_en ? '0 : div_cnt_q + DIV_W'(1);
    sam_idx_d  = sam_clk_en ? sam_idx_q + 2'd1 : sam_idx_q;
  end

  // Next-state and output logic for the IDLE/RUN/FLUSH sequencer.
  always_comb begin
    state_d         = state_q;
    stop_pend_d     = stop_pend_q;
    flush_cnt_d     = flush_cnt_q;
    sym_out_d       = sym_out_q;
    underflow_cnt_d = underflow_cnt_q;
    s_ready         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        sym_out_d   = '0;
        stop_pend_d = 1'b0;
        // A simultaneous stop cancels the start.
        if (start && !stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        s_ready = sym_clk_en & ~stop_pend_q;
        // A stop landing on a boundary is only seen at the following boundary.
        if (stop) stop_pend_d = 1'b1;
        if (sym_clk_en) begin
          if (stop_pend_q) begin
            // Entry boundary loads the first flush zero.
            sym_out_d   = '0;
            flush_cnt_d = FLUSH_LOAD;
            stop_pend_d = 1'b0;
            state_d     = ST_FLUSH;
          end else if (s_valid) begin
            sym_out_d = s_data;
          end else begin
            sym_out_d = '0;
            if (underflow_cnt_q != 16'hFFFF) underflow_cnt_d = underflow_cnt_q + 16'd1;
          end
        end
      end
      ST_FLUSH: begin
        if (sym_clk_en) begin
          sym_out_d = '0;
          if (flush_cnt_q == 8'd1) state_d = ST_IDLE;
          else                     flush_cnt_d = flush_cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      div_cnt_q       <= '0;
      sam_idx_q       <= '0;
      stop_pend_q     <= 1'b0;
      flush_cnt_q     <= '0;
      sym_out_q       <= '0;
      underflow_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      div_cnt_q       <= div_cnt_d;
      sam_idx_q       <= sam_idx_d;
      stop_pend_q     <= stop_pend_d;
      flush_cnt_q     <= flush_cnt_d;
      sym_out_q       <= sym_out_d;
      underflow_cnt_q <= underflow_cnt_d;
    end
  end

  assign sym_out       = sym_out_q;
  assign busy          = (state_q != ST_IDLE);
  assign underflow_cnt = underflow_cnt_q;

endmodule

// File: tb/tb_tx_sym_scheduler.sv
// tb_tx_sym_scheduler: scoreboard bench for tx_sym_scheduler with default
// parameters (4 clk/sample, 48 flush symbols).
module tb_tx_sym_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop, s_valid;
  logic [17:0] s_data;
  logic        s_ready, sam_clk_en, sym_clk_en, busy;
  logic [17:0] sym_out;
  logic [15:0] underflow_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int entry_cyc;
  logic [17:0] sb_q[$];
  logic [17:0] seq[4];

  tx_sym_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en), .sym_out(sym_out),
    .busy(busy), .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance to the next boundary cycle; s_ready must stay low off-boundary.
  task automatic to_boundary();
    int n = 0;
    while (!sym_clk_en && n < 64) begin
      check("rdy_off", {31'd0, s_ready}, 32'd0);
      tick();
      n++;
    end
    if (!sym_clk_en) check("bnd_timeout", {31'd0, sym_clk_en}, 32'd1);
  endtask

  // Drive one boundary cycle, push expected sym_out, pop and compare after the edge.
  task automatic sym_step(input logic v, input logic [17:0] d, input logic st, input logic sp,
                          input logic exp_rdy, input logic [17:0] exp_out);
    logic [17:0] e;
    s_valid = v; s_data = d; start = st; stop = sp;
    #1;
    check("s_ready", {31'd0, s_ready}, {31'd0, exp_rdy});
    sb_q.push_back(exp_out);
    tick();
    s_valid = 1'b0; start = 1'b0; stop = 1'b0;
    e = sb_q.pop_front();
    check("sym_out", {14'd0, sym_out}, {14'd0, e});
    $display("sym cyc=%0d v=%0b d=%0h rdy=%0b out=%0h exp=%0h", cyc, v, d, exp_rdy, sym_out, e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    seq[0] = 18'd32767;   // P1
    seq[1] = 18'd98301;   // P2
    seq[2] = 18'h38001;   // N1
    seq[3] = 18'h28003;   // N2
    reset = 1'b1; start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sam", {31'd0, sam_clk_en}, 32'd0);
    check("rst_sym", {31'd0, sym_clk_en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rdy", {31'd0, s_ready}, 32'd0);
    check("rst_out", {14'd0, sym_out}, 32'd0);
    check("rst_ufl", {16'd0, underflow_cnt}, 32'd0);
    reset = 1'b0;
    cyc = 0;

    // Strobe pattern while idle
    for (int k = 0; k < 48; k++) begin
      check("sam_en", {31'd0, sam_clk_en}, {31'd0, (k % 4) == 3});
      check("sym_en", {31'd0, sym_clk_en}, {31'd0, (k % 16) == 15});
      check("idle_busy", {31'd0, busy}, 32'd0);
      tick();
    end

    // start+stop together in IDLE: stays idle, no pop at next boundary
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", {31'd0, busy}, 32'd0);
    to_boundary();
    sym_step(1'b1, seq[0], 1'b0, 1'b0, 1'b0, 18'd0);

    // Continuous stream
    pulse_start();
    check("start_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      to_boundary();
      sym_step(1'b1, seq[i % 4], 1'b0, 1'b0, 1'b1, seq[i % 4]);
    end
    check("ufl_zero", {16'd0, underflow_cnt}, 32'd0);

    // Underflow for 3 boundaries, then resume
    for (int i = 0; i < 3; i++) begin
      to_boundary();
      sym_step(1'b0, seq[1], 1'b0, 1'b0, 1'b1, 18'd0);
    end
    check("ufl_three", {16'd0, underflow_cnt}, 32'd3);
    for (int i = 0; i < 4; i++) begin
      to_boundary();
      sym_step(1'b1, seq[i], 1'b0, 1'b0, 1'b1, seq[i]);
    end

    // stop on a boundary: that pop completes, flush starts next boundary
    to_boundary();
    sym_step(1'b1, seq[3], 1'b0, 1'b1, 1'b1, seq[3]);
    to_boundary();
    sym_step(1'b1, seq[0], 1'b0, 1'b0, 1'b0, 18'd0);
    entry_cyc = cyc;
    for (int i = 0; i < 47; i++) begin
      check("busy_flush", {31'd0, busy}, 32'd1);
      to_boundary();
      sym_step(1'b1, seq[1], (i == 10), (i == 20), 1'b0, 18'd0);
    end
    check("busy_fall", {31'd0, busy}, 32'd0);
    check("flush_len", cyc - entry_cyc, 32'd752);
    check("ufl_hold", {16'd0, underflow_cnt}, 32'd3);

    // Saturation: preload near the top, then underflow past it
    pulse_start();
    to_boundary();
    sym_step(1'b1, seq[2], 1'b0, 1'b0, 1'b1, seq[2]);
    force dut.underflow_cnt_q = 16'hFFFD;
    #1;
    release dut.underflow_cnt_q;
    check("ufl_preload", {16'd0, underflow_cnt}, 32'h0000FFFD);
    to_boundary();
    sym_step(1'b0, seq[0], 1'b0, 1'b0, 1'b1, 18'd0);
    check("ufl_fffe", {16'd0, underflow_cnt}, 32'h0000FFFE);
    to_boundary();
    sym_step(1'b0, seq[0], 1'b0, 1'b0, 1'b1, 18'd0);
    check("ufl_ffff", {16'd0, underflow_cnt}, 32'h0000FFFF);
    to_boundary();
    sym_step(1'b0, seq[0], 1'b0, 1'b0, 1'b1, 18'd0);
    check("ufl_sat", {16'd0, underflow_cnt}, 32'h0000FFFF);

    // stop mid-symbol: next boundary loads zero without popping
    repeat (5) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    to_boundary();
    sym_step(1'b1, seq[1], 1'b0, 1'b0, 1'b0, 18'd0);
    for (int i = 0; i < 3; i++) begin
      to_boundary();
      sym_step(1'b1, seq[1], 1'b0, 1'b0, 1'b0, 18'd0);
    end
    check("busy_mid", {31'd0, busy}, 32'd1);

    // Asynchronous reset mid-FLUSH
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_out", {14'd0, sym_out}, 32'd0);
    check("arst_ufl", {16'd0, underflow_cnt}, 32'd0);
    check("arst_sam", {31'd0, sam_clk_en}, 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    check("post_sam", {31'd0, sam_clk_en}, 32'd1);
    check("post_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
